// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one quotient bit per clock,
// 27-clock latency. Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise truncates.
module fp_div_seq #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] dataA_i,
   input  logic [DATA_WIDTH-1:0] dataB_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   typedef enum logic [1:0] {StIdle, StDiv, StPack} state_e;
   typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} special_e;

   state_e           state_q;
   special_e         special_q;
   logic             sign_q;
   logic [7:0]       ea_q, eb_q;
   logic [23:0]      mb_q;
   logic [25:0]      rem_q;
   logic [25:0]      quo_q;
   logic [4:0]       cnt_q;
   logic             valid_q;
   logic [31:0]      data_q;

   // Input classification, used only on the accepting edge
   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_frac, b_frac;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   special_e    special_in;

   always_comb begin
      a_exp  = dataA_i[30:23];
      b_exp  = dataB_i[30:23];
      a_frac = dataA_i[22:0];
      b_frac = dataB_i[22:0];
      a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
      b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
      a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
      b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
      a_zero = (a_exp == 8'h00);
      b_zero = (b_exp == 8'h00);
      special_in = SpNone;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         special_in = SpNan;
      end else if (b_zero || a_inf) begin
         special_in = SpInf;
      end else if (a_zero || b_inf) begin
         special_in = SpZero;
      end
   end

   // One restoring step: compare/subtract, then shift for the next bit
   logic [26:0] trial;
   logic        q_bit;
   logic [25:0] rem_sel;
   logic [25:0] rem_next;

   always_comb begin
      trial    = {1'b0, rem_q} - {3'b000, mb_q};
      q_bit    = ~trial[26];
      rem_sel  = q_bit ? trial[25:0] : rem_q;
      rem_next = {rem_sel[24:0], 1'b0};
   end

   // Normalise, optionally round, and pack
   logic signed [9:0] exp_raw, exp_r;
   logic [22:0]       frac_t, frac_r;
   logic [31:0]       pack_result;

`ifdef FP_DIV_ROUND_EN
   logic guard, sticky, round_up, carry;
`else
   logic unused_quo_lsb;
   assign unused_quo_lsb = quo_q[0];
`endif

   always_comb begin
      exp_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                + (quo_q[25] ? 10'sd127 : 10'sd126);
      frac_t  = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
`ifdef FP_DIV_ROUND_EN
      guard    = quo_q[25] ? quo_q[1] : quo_q[0];
      sticky   = (quo_q[25] & quo_q[0]) | (rem_q != 26'd0);
      round_up = guard & (sticky | frac_t[0]);
      {carry, frac_r} = {1'b0, frac_t} + {23'd0, round_up};
      exp_r    = exp_raw + (carry ? 10'sd1 : 10'sd0);
`else
      frac_r = frac_t;
      exp_r  = exp_raw;
`endif
      unique case (special_q)
         SpNan:   pack_result = 32'h7FC0_0000;
         SpInf:   pack_result = {sign_q, 8'hFF, 23'd0};
         SpZero:  pack_result = {sign_q, 31'd0};
         default: begin
            if (exp_raw <= 10'sd0) begin
               pack_result = {sign_q, 31'd0};
            end else if (exp_r >= 10'sd255) begin
               pack_result = {sign_q, 8'hFF, 23'd0};
            end else begin
               pack_result = {sign_q, exp_r[7:0], frac_r};
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         special_q <= SpNone;
         sign_q    <= 1'b0;
         ea_q      <= 8'd0;
         eb_q      <= 8'd0;
         mb_q      <= 24'd0;
         rem_q     <= 26'd0;
         quo_q     <= 26'd0;
         cnt_q     <= 5'd0;
         valid_q   <= 1'b0;
         data_q    <= 32'd0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  sign_q    <= dataA_i[31] ^ dataB_i[31];
                  ea_q      <= a_exp;
                  eb_q      <= b_exp;
                  rem_q     <= {2'b01, a_frac};
                  mb_q      <= {1'b1, b_frac};
                  quo_q     <= 26'd0;
                  special_q <= special_in;
                  cnt_q     <= 5'd25;
                  state_q   <= StDiv;
               end
            end
            StDiv: begin
               rem_q <= rem_next;
               quo_q <= {quo_q[24:0], q_bit};
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  state_q <= StPack;
               end
            end
            StPack: begin
               data_q  <= pack_result;
               valid_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o = (state_q == StIdle);
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: expected quotients queued at issue, popped on valid_o.
module tb_fp_div_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        ready, valid;
   logic [31:0] data;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   fp_div_seq #(.DATA_WIDTH(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .dataA_i (a),
      .dataB_i (b),
      .ready_o (ready),
      .valid_o (valid),
      .data_o  (data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted start; returns just after the accepting edge
   task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] exp_v);
      start = 1'b1;
      a     = xa;
      b     = xb;
      sb_q.push_back(exp_v);
      tick();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Waits (bounded) for valid_o; lat = edges after the accepting edge
   task automatic wait_valid(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid === 1'b1) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
      total++;
      if (data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", data); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_v;
      int busy_err = 0;
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      if (ready !== 1'b0) busy_err++;
      for (int i = 1; i <= 26; i++) begin
         tick();
         if (ready !== 1'b0 || valid !== 1'b0) busy_err++;
      end
      total++;
      if (busy_err != 0) begin bad++; $display("FAIL basic_busy: got %0d bad cycles want 0", busy_err); end
      tick();
      total++;
      if (valid !== 1'b1 || ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_latency: got valid=%b ready=%b want 1 1 after edge 27", valid, ready);
      end
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin bad++; $display("FAIL basic_data: got %h want %h", data, exp_v); end
      tick();
      total++;
      if (valid !== 1'b0 || data !== exp_v) begin
         bad++;
         $display("FAIL basic_pulse: got valid=%b data=%h want 0 %h", valid, data, exp_v);
      end
   endtask

   task automatic test_ops(input string name, input logic [31:0] opa[],
                           input logic [31:0] opb[], input logic [31:0] res[]);
      logic [31:0] exp_v;
      int lat;
      bit ok;
      for (int k = 0; k < opa.size(); k++) begin
         issue(opa[k], opb[k], res[k]);
         wait_valid(lat, ok);
         exp_v = sb_q.pop_front();
         total++;
         if (!ok || data !== exp_v || lat != 27) begin
            bad++;
            $display("FAIL %s_%0d: got %h lat=%0d want %h lat=27", name, k, data, lat, exp_v);
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] opa[] = '{32'h3F80_0000, 32'h3F80_0000};
      logic [31:0] opb[] = '{32'h4040_0000, 32'h3FC0_0000};
`ifdef FP_DIV_ROUND_EN
      logic [31:0] res[] = '{32'h3EAA_AAAB, 32'h3F2A_AAAB};
`else
      logic [31:0] res[] = '{32'h3EAA_AAAA, 32'h3F2A_AAAA};
`endif
      test_ops("rounding", opa, opb, res);
   endtask

   task automatic test_special();
      logic [31:0] opa[] = '{32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h4000_0000,
                             32'h7FC0_1234, 32'h7F80_0000};
      logic [31:0] opb[] = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h7F80_0000,
                             32'hC000_0000, 32'hFF80_0000};
      logic [31:0] res[] = '{32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000,
                             32'h7FC0_0000, 32'h7FC0_0000};
      test_ops("special", opa, opb, res);
   endtask

   task automatic test_range();
      logic [31:0] opa[] = '{32'h7F00_0000, 32'h0080_0000, 32'hC0C0_0000};
      logic [31:0] opb[] = '{32'h0080_0000, 32'h7F00_0000, 32'h4000_0000};
      logic [31:0] res[] = '{32'h7F80_0000, 32'h0000_0000, 32'hC040_0000};
      test_ops("range", opa, opb, res);
   endtask

   task automatic test_ignore_start();
      logic [31:0] exp_v;
      int lat = 0;
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      for (int e = 1; e <= 40; e++) begin
         if (e == 5 || e == 20) begin
            start = 1'b1;
            a     = 32'h3F80_0000;
            b     = 32'h4040_0000;
         end
         tick();
         start = 1'b0;
         if (valid === 1'b1) begin
            lat = e;
            break;
         end
      end
      exp_v = sb_q.pop_front();
      total++;
      if (lat != 27 || data !== exp_v) begin
         bad++;
         $display("FAIL ignore_start: got %h lat=%0d want %h lat=27", data, lat, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_v;
      int lat;
      bit ok;
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      wait_valid(lat, ok);
      exp_v = sb_q.pop_front();
      total++;
      if (!ok || data !== exp_v) begin bad++; $display("FAIL b2b_first: got %h want %h", data, exp_v); end
      issue(32'hC110_0000, 32'h4040_0000, 32'hC040_0000);
      wait_valid(lat, ok);
      exp_v = sb_q.pop_front();
      total++;
      if (!ok || lat != 27 || data !== exp_v) begin
         bad++;
         $display("FAIL b2b_second: got %h lat=%0d want %h lat=27", data, lat, exp_v);
      end
   endtask

   task automatic test_abort();
      logic [31:0] exp_v;
      int lat;
      bit ok;
      int stray = 0;
      issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
      for (int e = 1; e <= 9; e++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sb_q.pop_back());
      total++;
      if (ready !== 1'b1 || valid !== 1'b0 || data !== 32'd0) begin
         bad++;
         $display("FAIL abort_state: got ready=%b valid=%b data=%h want 1 0 0", ready, valid, data);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         if (valid !== 1'b0) stray++;
      end
      total++;
      if (stray != 0) begin bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", stray); end
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
      wait_valid(lat, ok);
      exp_v = sb_q.pop_front();
      total++;
      if (!ok || lat != 27 || data !== exp_v) begin
         bad++;
         $display("FAIL abort_recover: got %h lat=%0d want %h lat=27", data, lat, exp_v);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      test_reset();
      test_basic();
      test_rounding();
      test_special();
      test_range();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", sb_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
